// File: rtl/shift_sequencer.sv
// shift_sequencer: drives an external single-step shifter once per cycle to shift by 0..2^AMT_W-1.
// Optional SHIFT_SEQ_EARLY_EXIT_EN finishes early once the value reaches a fixed point of the op.
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] sh_out,
   output logic [WIDTH-1:0] sh_in,
   output logic [1:0]       sh_shift,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nstate;
   logic [WIDTH-1:0] acc;
   logic [AMT_W-1:0] cnt;
   logic [1:0] op_q;
   logic accept, fast, last;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
   // further steps cannot change a fixed point, so stopping there leaves the result unchanged
   function automatic logic fixed_pt(input logic [WIDTH-1:0] v, input logic [1:0] o);
      return (v == '0) || (o == 2'b11 && v == '1);
   endfunction
   assign fast = (amount == '0) || (op == 2'b00) || fixed_pt(din, op);
   assign last = (cnt == AMT_W'(1)) || fixed_pt(sh_out, op_q);
`else
   assign fast = (amount == '0) || (op == 2'b00);
   assign last = cnt == AMT_W'(1);
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= nstate;
   always_comb begin
      accept   = start && (state != RUN);
      nstate   = state == RUN ? (last ? DONE : RUN) : accept ? (fast ? DONE : RUN) : IDLE;
      busy     = state == RUN;
      done     = state == DONE;
      sh_shift = busy ? op_q : 2'b00;
      sh_in    = acc;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         acc    <= '0;
         cnt    <= '0;
         op_q   <= 2'b00;
         result <= '0;
      end else if (accept) begin
         acc  <= din;
         op_q <= op;
         cnt  <= amount;
         if (fast) result <= din;
      end else if (state == RUN) begin
         acc <= sh_out;
         cnt <= cnt - 1'b1;
         if (last) result <= sh_out;
      end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven check of shift_sequencer against a behavioural single-step shifter.
module tb_shift_sequencer;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [1:0] op = 2'b00;
   logic [3:0] amount = '0;
   logic [15:0] din = '0, sh_out, sh_in, result;
   logic [1:0] sh_shift;
   logic busy, done;
   int total = 0, bad = 0;
   typedef struct {
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] din;
      logic [15:0] res;
      int          lat;
   } vec_t;
   vec_t v[10];
   always #5 clk = ~clk;
   assign sh_out = sh_shift == 2'b01 ? {sh_in[14:0], 1'b0} :
                   sh_shift == 2'b10 ? {1'b0, sh_in[15:1]} :
                   sh_shift == 2'b11 ? {sh_in[15], sh_in[15:1]} : sh_in;
   shift_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .amount(amount), .din(din),
      .sh_out(sh_out), .sh_in(sh_in), .sh_shift(sh_shift), .busy(busy), .done(done), .result(result)
   );
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // caller is positioned at a negedge; start is accepted on the following posedge
   task automatic run_op(input logic [1:0] o, input logic [15:0] d, input logic [3:0] a,
                         input logic [15:0] res, input int lat, input int poke);
      logic [15:0] prev;
      int n;
      bit seen;
      prev = result;
      start = 1'b1; op = o; din = d; amount = a;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (poke != 0 && n == poke + 1) start = 1'b0;
         if (done) seen = 1;
         else begin
            chk("busy_in_run", busy, 1);
            chk("sh_shift_in_run", sh_shift, o);
            chk("result_held", result, prev);
            if (poke != 0 && n == poke) begin
               start = 1'b1; op = 2'b00; din = 16'hFFFF; amount = '0;
            end
         end
      end
      chk("latency", n, lat);
      chk("result", result, res);
      chk("busy_with_done", busy, 0);
      chk("sh_shift_idle", sh_shift, 0);
   endtask
   initial begin
      v[0] = '{2'b01, 4'd4,  16'h0001, 16'h0010, 5};
      v[1] = '{2'b11, 4'd3,  16'h8000, 16'hF000, 4};
      v[2] = '{2'b10, 4'd15, 16'h8000, 16'h0001, 16};
      v[3] = '{2'b00, 4'd7,  16'h1234, 16'h1234, 1};
      v[4] = '{2'b01, 4'd0,  16'hABCD, 16'hABCD, 1};
      v[5] = '{2'b01, 4'd8,  16'h00FF, 16'hFF00, 9};
      v[6] = '{2'b11, 4'd2,  16'h7FFF, 16'h1FFF, 3};
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
      v[7] = '{2'b10, 4'd10, 16'h0004, 16'h0000, 4};
      v[8] = '{2'b11, 4'd5,  16'hFFFF, 16'hFFFF, 1};
`else
      v[7] = '{2'b10, 4'd10, 16'h0004, 16'h0000, 11};
      v[8] = '{2'b11, 4'd5,  16'hFFFF, 16'hFFFF, 6};
`endif
      v[9] = '{2'b01, 4'd1,  16'h8001, 16'h0002, 2};
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_sh_shift", sh_shift, 0);
      chk("rst_sh_in", sh_in, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) run_op(v[i].op, v[i].din, v[i].amt, v[i].res, v[i].lat, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_not_busy", busy, 0);
      chk("idle_result_held", result, 16'h0002);
      run_op(2'b01, 16'h0003, 4'd6, 16'h00C0, 7, 2);
      @(negedge clk);
      start = 1'b1; op = 2'b01; din = 16'h0001; amount = 4'd10;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_sh_shift", sh_shift, 0);
      chk("mid_rst_sh_in", sh_in, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      run_op(2'b01, 16'h0001, 4'd4, 16'h0010, 5, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
